// File: rtl/pulse_gen_if.sv
// Config/control/status bundle for the programmable pulse generator.
// The master side is the controller, and the slave side is the generator itself.
interface pulse_gen_if #(
  parameter int CNT_W = 32,
  parameter int NUM_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic [NUM_W-1:0] cfg_num;
  logic             start;
  logic             stop;
  logic             wave_out;
  logic             busy;
  logic             done;
  logic [31:0]      pulse_cnt;

  modport master (
    output cfg_valid, cfg_period, cfg_high, cfg_num, start, stop,
    input  cfg_ready, wave_out, busy, done, pulse_cnt
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_high, cfg_num, start, stop,
    output cfg_ready, wave_out, busy, done, pulse_cnt
  );
endinterface

// File: rtl/pulse_gen.sv
// Programmable square/pulse generator with a double-buffered config.
// A new config only takes effect at the start of a run or at a period boundary.
module pulse_gen #(
  parameter int CNT_W = 32,
  parameter int NUM_W = 16
) (
  input  logic          sys_clk,
  input  logic          rst,
  pulse_gen_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_ph, w_ph_next;
  logic [CNT_W-1:0] r_per, r_high;
  logic [NUM_W-1:0] r_num;
  logic [CNT_W-1:0] r_pend_per, r_pend_high;
  logic [NUM_W-1:0] r_pend_num;
  logic             r_pend_full;
  logic             r_stop, w_stop_next;
  logic             r_wave;
  logic             r_done, w_done_next;
  logic [31:0]      r_pulse_cnt, w_cnt_next;
  logic             w_apply;

  logic [CNT_W-1:0] w_clamp_per, w_high_min1, w_clamp_high;
  logic [31:0]      w_cnt_plus;
  logic             w_burst_end;

  // Clamp so that the output always has at least one high and one low cycle
  assign w_clamp_per  = (r_pend_per < CNT_W'(2)) ? CNT_W'(2) : r_pend_per;
  assign w_high_min1  = (r_pend_high == '0) ? CNT_W'(1) : r_pend_high;
  assign w_clamp_high = (w_high_min1 > w_clamp_per - CNT_W'(1)) ?
                        (w_clamp_per - CNT_W'(1)) : w_high_min1;

  assign w_cnt_plus  = r_pulse_cnt + 32'd1;
  assign w_burst_end = (r_num != '0) && (w_cnt_plus == 32'(r_num));

  always_comb begin
    w_state_next = r_state;
    w_ph_next    = r_ph;
    w_cnt_next   = r_pulse_cnt;
    w_stop_next  = r_stop;
    w_apply      = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stop_next = 1'b0;
        w_apply     = r_pend_full;
        if (bus.start) begin
          w_state_next = S_HIGH;
          w_ph_next    = '0;
          w_cnt_next   = '0;
        end
      end
      S_HIGH: begin
        w_stop_next = r_stop | bus.stop;
        w_ph_next   = r_ph + CNT_W'(1);
        if (r_ph == r_high - CNT_W'(1)) w_state_next = S_LOW;
      end
      S_LOW: begin
        w_stop_next = r_stop | bus.stop;
        w_ph_next   = r_ph + CNT_W'(1);
        if (r_ph == r_per - CNT_W'(1)) begin
          // Period boundary: count it, swap in any pending config, decide to continue
          w_ph_next   = '0;
          w_apply     = r_pend_full;
          w_cnt_next  = (r_pulse_cnt == '1) ? r_pulse_cnt : w_cnt_plus;
          w_stop_next = 1'b0;
          if (r_stop || bus.stop || w_burst_end) begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = S_HIGH;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ph        <= '0;
      r_per       <= CNT_W'(2);
      r_high      <= CNT_W'(1);
      r_num       <= '0;
      r_pend_per  <= '0;
      r_pend_high <= '0;
      r_pend_num  <= '0;
      r_pend_full <= 1'b0;
      r_stop      <= 1'b0;
      r_wave      <= 1'b0;
      r_done      <= 1'b0;
      r_pulse_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ph        <= w_ph_next;
      r_stop      <= w_stop_next;
      r_done      <= w_done_next;
      r_pulse_cnt <= w_cnt_next;
      r_wave      <= (r_state == S_HIGH);
      if (w_apply) begin
        r_per       <= w_clamp_per;
        r_high      <= w_clamp_high;
        r_num       <= r_pend_num;
        r_pend_full <= 1'b0;
      end else if (bus.cfg_valid && !r_pend_full) begin
        r_pend_per  <= bus.cfg_period;
        r_pend_high <= bus.cfg_high;
        r_pend_num  <= bus.cfg_num;
        r_pend_full <= 1'b1;
      end
    end
  end

  assign bus.cfg_ready = ~r_pend_full;
  assign bus.wave_out  = r_wave;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen: a table of burst configs plus hand-written
// sequences for config swaps, stop, reset mid-run and start/stop collisions.
module tb_pulse_gen;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pulse_gen_if #(.CNT_W(32), .NUM_W(16)) bus ();

  pulse_gen #(.CNT_W(32), .NUM_W(16)) dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  typedef struct {
    int unsigned per;
    int unsigned high;
    int unsigned num;
    int unsigned exp_p;
    int unsigned exp_h;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
    end else begin
      $display("[TB] ok   %s: %0d", nm, act);
    end
  endtask

  task automatic load_cfg(input int unsigned p, input int unsigned h, input int unsigned n);
    bus.cfg_valid  = 1'b1;
    bus.cfg_period = p;
    bus.cfg_high   = h;
    bus.cfg_num    = 16'(n);
    tick();
    bus.cfg_valid = 1'b0;
    chk("cfg_ready_after_accept", 32'(bus.cfg_ready), 0);
    tick();
    chk("cfg_ready_after_apply", 32'(bus.cfg_ready), 1);
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      if (bus.done === 1'b1) seen = 1;
      else tick();
    end
    chk(nm, 32'(seen), 1);
    tick();
  endtask

  initial begin
    int we, be, de, tot, c;
    logic ew;

    vecs[0] = '{per: 10, high: 3, num: 4, exp_p: 10, exp_h: 3};
    vecs[1] = '{per: 1,  high: 0, num: 3, exp_p: 2,  exp_h: 1};
    vecs[2] = '{per: 5,  high: 9, num: 2, exp_p: 5,  exp_h: 4};
    vecs[3] = '{per: 4,  high: 2, num: 1, exp_p: 4,  exp_h: 2};
    vecs[4] = '{per: 3,  high: 3, num: 2, exp_p: 3,  exp_h: 2};
    vecs[5] = '{per: 0,  high: 5, num: 2, exp_p: 2,  exp_h: 1};

    bus.cfg_valid = 1'b0; bus.cfg_period = '0; bus.cfg_high = '0; bus.cfg_num = '0;
    bus.start = 1'b0; bus.stop = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_wave", 32'(bus.wave_out), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_pulse_cnt", bus.pulse_cnt, 0);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 1);

    // Table: bursts with exact waveform, busy and done timing
    for (int v = 0; v < 6; v++) begin
      load_cfg(vecs[v].per, vecs[v].high, vecs[v].num);
      start_run();
      we = 0; be = 0; de = 0;
      tot = int'(vecs[v].num * vecs[v].exp_p);
      for (int cc = 1; cc <= tot + 4; cc++) begin
        ew = (cc >= 2 && cc <= tot + 1 && ((cc - 2) % int'(vecs[v].exp_p)) < int'(vecs[v].exp_h));
        if (bus.wave_out !== ew) we++;
        if (bus.busy !== 1'(cc <= tot)) be++;
        if (bus.done !== 1'(cc == tot + 1)) de++;
        tick();
      end
      chk($sformatf("v%0d_wave_errs", v), 32'(we), 0);
      chk($sformatf("v%0d_busy_errs", v), 32'(be), 0);
      chk($sformatf("v%0d_done_errs", v), 32'(de), 0);
      chk($sformatf("v%0d_pulse_cnt", v), bus.pulse_cnt, 32'(vecs[v].num));
    end

    // Config update mid-HIGH: 8/4 period finishes, then 6/2
    load_cfg(8, 4, 0);
    start_run();
    we = 0;
    for (c = 1; c <= 17; c++) begin
      if (c == 2) begin
        bus.cfg_valid = 1'b1; bus.cfg_period = 6; bus.cfg_high = 2; bus.cfg_num = 0;
      end
      if (c == 3) bus.cfg_valid = 1'b0;
      if (c == 3) chk("t2_ready_c3", 32'(bus.cfg_ready), 0);
      if (c == 8) chk("t2_ready_c8", 32'(bus.cfg_ready), 0);
      if (c == 9) chk("t2_ready_c9", 32'(bus.cfg_ready), 1);
      ew = (c >= 2 && c <= 5) || (c >= 10 && c <= 11) || (c >= 16 && c <= 17);
      if (bus.wave_out !== ew) we++;
      tick();
    end
    chk("t2_wave_errs", 32'(we), 0);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    wait_done("t2_done_seen", 20);

    // Graceful stop in the 3rd period of a continuous 10/5 run
    load_cfg(10, 5, 0);
    start_run();
    we = 0; de = 0; be = 0;
    for (c = 1; c <= 33; c++) begin
      bus.stop = (c == 22);
      ew = (c >= 2 && c <= 31 && ((c - 2) % 10) < 5);
      if (bus.wave_out !== ew) we++;
      if (bus.done !== 1'(c == 31)) de++;
      if (bus.busy !== 1'(c <= 30)) be++;
      tick();
    end
    chk("t4_wave_errs", 32'(we), 0);
    chk("t4_done_errs", 32'(de), 0);
    chk("t4_busy_errs", 32'(be), 0);
    chk("t4_pulse_cnt", bus.pulse_cnt, 3);

    // Reset mid-HIGH of the 2nd period with a pending config held
    load_cfg(10, 5, 0);
    start_run();
    for (c = 1; c < 13; c++) begin
      bus.cfg_valid = (c == 12);
      tick();
    end
    bus.cfg_valid = 1'b0;
    chk("t5_cnt_before_rst", bus.pulse_cnt, 1);
    chk("t5_ready_before_rst", 32'(bus.cfg_ready), 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_wave", 32'(bus.wave_out), 0);
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_pulse_cnt", bus.pulse_cnt, 0);
    chk("t5_cfg_ready", 32'(bus.cfg_ready), 1);
    de = 0;
    for (c = 0; c < 4; c++) begin
      if (bus.done !== 1'b0) de++;
      tick();
    end
    chk("t5_no_done", 32'(de), 0);

    // start+stop together in IDLE, then two config writes in one period
    load_cfg(8, 4, 0);
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    we = 0;
    for (c = 1; c <= 21; c++) begin
      if (c == 2) begin
        bus.cfg_valid = 1'b1; bus.cfg_period = 6; bus.cfg_high = 3; bus.cfg_num = 0;
      end
      if (c == 3) begin
        bus.cfg_period = 4; bus.cfg_high = 1;
        chk("t6_ready_stall_c3", 32'(bus.cfg_ready), 0);
      end
      if (c == 9)  chk("t6_ready_c9", 32'(bus.cfg_ready), 1);
      if (c == 10) begin
        bus.cfg_valid = 1'b0;
        chk("t6_ready_c10", 32'(bus.cfg_ready), 0);
      end
      if (c == 12) chk("t6_busy_c12", 32'(bus.busy), 1);
      if (c == 15) chk("t6_ready_c15", 32'(bus.cfg_ready), 1);
      ew = (c >= 2 && c <= 5) || (c >= 10 && c <= 12) || (c == 16) || (c == 20);
      if (bus.wave_out !== ew) we++;
      tick();
    end
    chk("t6_wave_errs", 32'(we), 0);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    wait_done("t6_done_seen", 20);
    chk("t6_busy_after", 32'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
